// File: rtl/ecc_pkg.sv
// ecc_pkg: widths, check-bit masks and codeword layout for the 32-bit SEC
// code. The encoder and the SEC decoder both use this package.
package ecc_pkg;

  localparam int DATA_W = 32;
  localparam int CHK_W  = 8;
  localparam int CW_W   = 40;

  // Each mask selects the data bits whose XOR forms one check bit.
  localparam logic [DATA_W-1:0] CHK_MASK0 = 32'h00FF_1111;
  localparam logic [DATA_W-1:0] CHK_MASK1 = 32'hFF00_2222;
  localparam logic [DATA_W-1:0] CHK_MASK2 = 32'h0F0F_4444;
  localparam logic [DATA_W-1:0] CHK_MASK3 = 32'hF0F0_8888;
  localparam logic [DATA_W-1:0] CHK_MASK4 = 32'h1111_00FF;
  localparam logic [DATA_W-1:0] CHK_MASK5 = 32'h2222_FF00;
  localparam logic [DATA_W-1:0] CHK_MASK6 = 32'h4444_0F0F;
  localparam logic [DATA_W-1:0] CHK_MASK7 = 32'h8888_F0F0;

  typedef logic [CHK_W-1:0][DATA_W-1:0] chk_masks_t;

  localparam chk_masks_t CHK_MASKS = {CHK_MASK7, CHK_MASK6, CHK_MASK5, CHK_MASK4,
                                      CHK_MASK3, CHK_MASK2, CHK_MASK1, CHK_MASK0};

  // Codeword layout: check bits on top, data in the low 32 bits.
  typedef struct packed {
    logic [CHK_W-1:0]  chk;
    logic [DATA_W-1:0] data;
  } ecc_cw_t;

  // Check bits of a data word; bit i is the parity of data & CHK_MASKS[i].
  function automatic logic [CHK_W-1:0] ecc_chk(input logic [DATA_W-1:0] data);
    logic [CHK_W-1:0] c;
    c = '0;
    for (int i = 0; i < CHK_W; i++) begin
      c[i] = ^(data & CHK_MASKS[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/ecc_chk_gen.sv
// ecc_chk_gen: purely combinational check-bit generator (32 data in, 8 out).
module ecc_chk_gen
  import ecc_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CHK_W-1:0]  chk
);

  // Parity of each masked group of data bits.
  always_comb begin
    chk = ecc_chk(data);
  end

endmodule

// File: rtl/ecc_sec_encoder.sv
// ecc_sec_encoder: two-stage pipelined SEC encoder with a delivered-word
// counter. Optional error injection is built when ECC_ENC_ERRINJ_EN is
// defined; the default build has no injection ports and no injection logic.
//
// Handshake (both sides): a word moves when valid && ready are both high at
// the rising edge of CK. in_ready depends only on the stage valids and
// out_ready, never on in_valid. out_valid/out_cw hold stable while
// out_ready is low.
module ecc_sec_encoder
  import ecc_pkg::*;
(
  input  logic              CK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   out_cw,
  output logic [15:0]       word_cnt
`ifdef ECC_ENC_ERRINJ_EN
  ,
  input  logic              inj_en,
  input  logic [5:0]        inj_pos
`endif
);

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [CHK_W-1:0]  s1_chk;
  logic              s2_valid;
  logic [CW_W-1:0]   s2_cw;
  logic [15:0]       cnt_q;
  logic [CHK_W-1:0]  gen_chk;
  logic              s1_load;
  logic              s2_load;
  logic              in_fire;
  logic              out_fire;
  logic [CW_W-1:0]   flip_mask;
  ecc_cw_t           cw_next;

`ifdef ECC_ENC_ERRINJ_EN
  logic              s1_inj_en;
  logic [5:0]        s1_inj_pos;
`endif

  ecc_chk_gen u_chk_gen (
    .data (in_data),
    .chk  (gen_chk)
  );

  // Stage load conditions; a stage advances when empty or when its
  // successor takes its word.
  always_comb begin
    s2_load  = !s2_valid || out_ready;
    s1_load  = !s1_valid || s2_load;
    in_fire  = in_valid && s1_load;
    out_fire = s2_valid && out_ready;
  end

  assign in_ready  = s1_load;
  assign out_valid = s2_valid;
  assign out_cw    = s2_cw;
  assign word_cnt  = cnt_q;

  // Bit to invert in the stage-2 codeword (none unless injection is built).
  always_comb begin
    flip_mask = '0;
`ifdef ECC_ENC_ERRINJ_EN
    if (s1_inj_en && (s1_inj_pos < 6'd40)) begin
      flip_mask = {{(CW_W-1){1'b0}}, 1'b1} << s1_inj_pos;
    end
`endif
  end

  // Assemble the codeword presented to stage 2.
  always_comb begin
    cw_next      = '0;
    cw_next.data = s1_data;
    cw_next.chk  = s1_chk;
  end

  // Stage 1: data word and its group parities.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_chk   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_fire) begin
        s1_data <= in_data;
        s1_chk  <= gen_chk;
      end
    end
  end

`ifdef ECC_ENC_ERRINJ_EN
  // Injection controls travel with the word through stage 1.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      s1_inj_en  <= 1'b0;
      s1_inj_pos <= '0;
    end else if (in_fire) begin
      s1_inj_en  <= inj_en;
      s1_inj_pos <= inj_pos;
    end
  end
`endif

  // Stage 2: final codeword; held while downstream stalls.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      s2_valid <= 1'b0;
      s2_cw    <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_cw <= cw_next ^ flip_mask;
      end
    end
  end

  // Delivered-codeword counter, wraps naturally at 16 bits.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (out_fire) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule
